fwrisc_dbus_bridge: RTL and testbench

//  Downstream consumer of the core data-bus master (dvalid/daddr/dwdata/dwstb/dwrite -> drdata/dready).

---
 rtl/fwrisc_dbus_bridge_pkg.sv | 36 +++
 rtl/fwrisc_dbus_decode.sv | 25 ++
 rtl/fwrisc_dbus_bridge.sv | 164 ++++++++++++++++
 tb/tb_fwrisc_dbus_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwrisc_dbus_bridge_pkg.sv
// Shared definitions for the fwrisc data-bus bridge: FSM state encoding,
// default region map, the latched request context and a region-match helper.
// No ports (package).
package fwrisc_dbus_bridge_pkg;

  // FSM states of the bridge
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAM_WAIT = 3'd1,
    ST_RAM_RSP  = 3'd2,
    ST_IO_WAIT  = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  // Default memory map (also used by the software linker map)
  localparam logic [31:0] DEF_RAM_BASE   = 32'h8000_0000;
  localparam int unsigned DEF_RAM_ADDR_W = 14;
  localparam logic [31:0] DEF_IO_BASE    = 32'h8001_0000;
  localparam int unsigned DEF_IO_ADDR_W  = 12;
  localparam int unsigned DEF_IO_TIMEOUT = 16;
  localparam logic [31:0] DEF_ERR_DATA   = 32'hDEAD_BEEF;

  // Context of the access in flight, kept for the response phase
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
  } req_t;

  // True when addr falls in the naturally aligned region of 2^lsb bytes at base
  function automatic logic region_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned lsb);
    return (addr >> lsb) == (base >> lsb);
  endfunction

endpackage

// File: rtl/fwrisc_dbus_decode.sv
// Combinational region decoder for the data-bus bridge.
// Ports:
//   addr      in  32  byte address of the request
//   ram_hit_c out 1   address lies in the SRAM region
//   io_hit_c  out 1   address lies in the IO region (and not in SRAM)
module fwrisc_dbus_decode
  import fwrisc_dbus_bridge_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = DEF_RAM_BASE,
  parameter int unsigned RAM_ADDR_W = DEF_RAM_ADDR_W,
  parameter logic [31:0] IO_BASE    = DEF_IO_BASE,
  parameter int unsigned IO_ADDR_W  = DEF_IO_ADDR_W
) (
  input  logic [31:0] addr,
  output logic        ram_hit_c,
  output logic        io_hit_c
);

  // RAM wins if a misconfigured map makes the regions overlap
  always_comb begin
    ram_hit_c = region_hit(addr, RAM_BASE, RAM_ADDR_W + 2);
    io_hit_c  = !ram_hit_c && region_hit(addr, IO_BASE, IO_ADDR_W);
  end

endmodule

// File: rtl/fwrisc_dbus_bridge.sv
// Data-bus bridge: completes every core access with exactly one dready pulse,
// routing it to on-chip SRAM, a memory-mapped IO port (with timeout), or
// returning an error for unmapped space.
// Ports:
//   clock, reset_n                    clock / async active-low reset
//   dvalid,daddr,dwdata,dwstb,dwrite  core request (held until dready)
//   drdata, dready                    core response (one-cycle pulse)
//   ram_en,ram_we,ram_addr,ram_wdata,ram_wstb / ram_rdata   SRAM port
//   io_valid,io_addr,io_wdata,io_wstb,io_write / io_rdata,io_ready  IO port
//   bus_err, err_addr                 error pulse and address of last error
module fwrisc_dbus_bridge
  import fwrisc_dbus_bridge_pkg::*;
#(
  parameter logic [31:0] RAM_BASE   = DEF_RAM_BASE,
  parameter int unsigned RAM_ADDR_W = DEF_RAM_ADDR_W,
  parameter logic [31:0] IO_BASE    = DEF_IO_BASE,
  parameter int unsigned IO_ADDR_W  = DEF_IO_ADDR_W,
  parameter int unsigned IO_TIMEOUT = DEF_IO_TIMEOUT,
  parameter logic [31:0] ERR_DATA   = DEF_ERR_DATA
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  dvalid,
  input  logic [31:0]           daddr,
  input  logic [31:0]           dwdata,
  input  logic [3:0]            dwstb,
  input  logic                  dwrite,
  output logic [31:0]           drdata,
  output logic                  dready,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_wstb,
  input  logic [31:0]           ram_rdata,
  output logic                  io_valid,
  output logic [IO_ADDR_W-1:0]  io_addr,
  output logic [31:0]           io_wdata,
  output logic [3:0]            io_wstb,
  output logic                  io_write,
  input  logic [31:0]           io_rdata,
  input  logic                  io_ready,
  output logic                  bus_err,
  output logic [31:0]           err_addr
);

  localparam int unsigned    CNT_W    = $clog2(IO_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  req_t             req;
  logic             ram_hit_c;
  logic             io_hit_c;

  // Region decode of the incoming address
  fwrisc_dbus_decode #(
    .RAM_BASE  (RAM_BASE),
    .RAM_ADDR_W(RAM_ADDR_W),
    .IO_BASE   (IO_BASE),
    .IO_ADDR_W (IO_ADDR_W)
  ) u_decode (
    .addr     (daddr),
    .ram_hit_c(ram_hit_c),
    .io_hit_c (io_hit_c)
  );

  // Access FSM with registered outputs and IO timeout counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      req       <= '0;
      drdata    <= '0;
      dready    <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_wstb  <= '0;
      io_valid  <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
      io_wstb   <= '0;
      io_write  <= 1'b0;
      bus_err   <= 1'b0;
      err_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dvalid) begin
            req <= '{addr: daddr, write: dwrite};
            if (ram_hit_c) begin
              ram_en    <= 1'b1;
              ram_we    <= dwrite;
              ram_addr  <= daddr[RAM_ADDR_W+1:2];
              ram_wdata <= dwdata;
              ram_wstb  <= dwrite ? dwstb : 4'b0000;
              state     <= ST_RAM_WAIT;
            end else if (io_hit_c) begin
              io_valid <= 1'b1;
              io_addr  <= daddr[IO_ADDR_W-1:0];
              io_wdata <= dwdata;
              io_wstb  <= dwrite ? dwstb : 4'b0000;
              io_write <= dwrite;
              cnt      <= '0;
              state    <= ST_IO_WAIT;
            end else begin
              // Unmapped: answer immediately with an error
              dready   <= 1'b1;
              drdata   <= ERR_DATA;
              bus_err  <= 1'b1;
              err_addr <= daddr;
              state    <= ST_DONE;
            end
          end
        end

        ST_RAM_WAIT: begin
          ram_en   <= 1'b0;
          ram_we   <= 1'b0;
          ram_wstb <= 4'b0000;
          state    <= ST_RAM_RSP;
        end

        ST_RAM_RSP: begin
          dready <= 1'b1;
          drdata <= req.write ? 32'h0 : ram_rdata;
          state  <= ST_DONE;
        end

        ST_IO_WAIT: begin
          // io_ready takes precedence over a simultaneous timeout
          if (io_ready) begin
            io_valid <= 1'b0;
            dready   <= 1'b1;
            drdata   <= req.write ? 32'h0 : io_rdata;
            state    <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            io_valid <= 1'b0;
            dready   <= 1'b1;
            drdata   <= ERR_DATA;
            bus_err  <= 1'b1;
            err_addr <= req.addr;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          // dvalid is still up this cycle; ignore it so the access is not repeated
          dready  <= 1'b0;
          drdata  <= '0;
          bus_err <= 1'b0;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_dbus_bridge.sv
// Self-checking bench for fwrisc_dbus_bridge: directed scenarios followed by
// randomized accesses, checked against a region/latency/memory reference model.
module tb_fwrisc_dbus_bridge;

  localparam logic [31:0] RAM_BASE   = 32'h8000_0000;
  localparam logic [31:0] IO_BASE    = 32'h8001_0000;
  localparam int          IO_TIMEOUT = 16;
  localparam logic [31:0] ERR_DATA   = 32'hDEAD_BEEF;
  localparam int          RAM_WORDS  = 16384;

  logic        clock;
  logic        reset_n;
  logic        dvalid;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwstb;
  logic        dwrite;
  logic [31:0] drdata;
  logic        dready;
  logic        ram_en;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstb;
  logic [31:0] ram_rdata;
  logic        io_valid;
  logic [11:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstb;
  logic        io_write;
  logic [31:0] io_rdata;
  logic        io_ready;
  logic        bus_err;
  logic [31:0] err_addr;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sram    [RAM_WORDS];
  logic [31:0] ref_mem [RAM_WORDS];
  logic [31:0] ref_err_addr;

  fwrisc_dbus_bridge dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .dvalid   (dvalid),
    .daddr    (daddr),
    .dwdata   (dwdata),
    .dwstb    (dwstb),
    .dwrite   (dwrite),
    .drdata   (drdata),
    .dready   (dready),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_wstb (ram_wstb),
    .ram_rdata(ram_rdata),
    .io_valid (io_valid),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wstb  (io_wstb),
    .io_write (io_write),
    .io_rdata (io_rdata),
    .io_ready (io_ready),
    .bus_err  (bus_err),
    .err_addr (err_addr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous SRAM device: read data appears the cycle after ram_en
  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we)
        for (int b = 0; b < 4; b++)
          if (ram_wstb[b]) sram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= sram[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 = unmapped, 1 = RAM (64KB region), 2 = IO (4KB region)
  function automatic int region_of(input logic [31:0] a);
    if (a / 32'h1_0000 == RAM_BASE / 32'h1_0000) return 1;
    if (a / 32'h1000 == IO_BASE / 32'h1000) return 2;
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_drdata"},   drdata, 32'h0);
    chk({tag, "_dready"},   32'(dready), 32'h0);
    chk({tag, "_ram_en"},   32'(ram_en), 32'h0);
    chk({tag, "_ram_we"},   32'(ram_we), 32'h0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    chk({tag, "_ram_wstb"}, 32'(ram_wstb), 32'h0);
    chk({tag, "_io_valid"}, 32'(io_valid), 32'h0);
    chk({tag, "_io_addr"},  32'(io_addr), 32'h0);
    chk({tag, "_io_wdata"}, io_wdata, 32'h0);
    chk({tag, "_io_wstb"},  32'(io_wstb), 32'h0);
    chk({tag, "_io_write"}, 32'(io_write), 32'h0);
    chk({tag, "_bus_err"},  32'(bus_err), 32'h0);
    chk({tag, "_err_addr"}, err_addr, 32'h0);
  endtask

  // One complete core access; io_delay = io_valid cycles before io_ready is raised
  task automatic access(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic wr,
                        input int io_delay, input logic [31:0] io_data);
    int          reg_kind = region_of(a);
    int          word = int'((a % 32'h1_0000) / 4);
    int          exp_cyc, exp_ram_cnt, exp_io_cnt;
    logic [31:0] exp_data;
    logic        exp_err;
    int          got_cyc = -1;
    int          pulses = 0, leak = 0, ram_cnt = 0, io_cnt = 0;
    logic [31:0] got_data = '0;
    logic        got_err = 1'b0;
    logic [13:0] c_ram_addr = '0;
    logic        c_ram_we = 1'b0;
    logic [3:0]  c_ram_wstb = '0, c_io_wstb = '0;
    logic [31:0] c_ram_wdata = '0, c_io_wdata = '0;
    logic [11:0] c_io_addr = '0;
    logic        c_io_write = 1'b0;

    exp_ram_cnt = 0;
    exp_io_cnt  = 0;
    exp_err     = 1'b0;
    if (reg_kind == 1) begin
      exp_cyc     = 3;
      exp_data    = wr ? 32'h0 : ref_mem[word];
      exp_ram_cnt = 1;
      if (wr)
        for (int b = 0; b < 4; b++)
          if (ws[b]) ref_mem[word][8*b +: 8] = wd[8*b +: 8];
    end else if (reg_kind == 2) begin
      if (io_delay < IO_TIMEOUT) begin
        exp_cyc    = io_delay + 2;
        exp_data   = wr ? 32'h0 : io_data;
        exp_io_cnt = io_delay + 1;
      end else begin
        exp_cyc      = IO_TIMEOUT + 1;
        exp_data     = ERR_DATA;
        exp_err      = 1'b1;
        exp_io_cnt   = IO_TIMEOUT;
        ref_err_addr = a;
      end
    end else begin
      exp_cyc      = 1;
      exp_data     = ERR_DATA;
      exp_err      = 1'b1;
      ref_err_addr = a;
    end

    @(negedge clock);
    daddr  = a;
    dwdata = wd;
    dwstb  = ws;
    dwrite = wr;
    dvalid = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clock);
      #1;
      io_ready = 1'b0;
      io_rdata = $urandom;
      if (ram_en) begin
        ram_cnt++;
        c_ram_addr  = ram_addr;
        c_ram_we    = ram_we;
        c_ram_wstb  = ram_wstb;
        c_ram_wdata = ram_wdata;
      end
      if (io_valid) begin
        io_cnt++;
        c_io_addr  = io_addr;
        c_io_wstb  = io_wstb;
        c_io_wdata = io_wdata;
        c_io_write = io_write;
        if (io_cnt == io_delay + 1) begin
          io_ready = 1'b1;
          io_rdata = io_data;
        end
      end
      if (dready) begin
        pulses++;
        if (got_cyc < 0) begin
          got_cyc  = cyc;
          got_data = drdata;
          got_err  = bus_err;
        end
      end else if (drdata != 32'h0 || bus_err) begin
        leak++;
      end
      // Master keeps dvalid through the cycle after dready, then drops it
      if (got_cyc > 0 && cyc == got_cyc + 1) dvalid = 1'b0;
      if (got_cyc > 0 && cyc == got_cyc + 3) break;
    end
    dvalid   = 1'b0;
    io_ready = 1'b0;

    chk({tag, "_dready_cycle"}, 32'(got_cyc), 32'(exp_cyc));
    chk({tag, "_drdata"},       got_data, exp_data);
    chk({tag, "_bus_err"},      32'(got_err), 32'(exp_err));
    chk({tag, "_err_addr"},     err_addr, ref_err_addr);
    chk({tag, "_dready_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_idle_leak"},    32'(leak), 32'd0);
    chk({tag, "_ram_en_cycles"}, 32'(ram_cnt), 32'(exp_ram_cnt));
    chk({tag, "_io_valid_cycles"}, 32'(io_cnt), 32'(exp_io_cnt));
    if (reg_kind == 1) begin
      chk({tag, "_ram_addr"}, 32'(c_ram_addr), 32'(word));
      chk({tag, "_ram_we"},   32'(c_ram_we), 32'(wr));
      if (wr) begin
        chk({tag, "_ram_wstb"},  32'(c_ram_wstb), 32'(ws));
        chk({tag, "_ram_wdata"}, c_ram_wdata, wd);
      end
    end else if (reg_kind == 2) begin
      chk({tag, "_io_addr"},  32'(c_io_addr), a % 32'h1000);
      chk({tag, "_io_write"}, 32'(c_io_write), 32'(wr));
      if (wr) begin
        chk({tag, "_io_wstb"},  32'(c_io_wstb), 32'(ws));
        chk({tag, "_io_wdata"}, c_io_wdata, wd);
      end
    end
  endtask

  initial begin
    int          extra_pulses;
    logic [31:0] a;
    int          kind;
    logic        wr;

    for (int i = 0; i < RAM_WORDS; i++) begin
      sram[i]    = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ref_err_addr = 32'h0;
    reset_n  = 1'b0;
    dvalid   = 1'b0;
    daddr    = '0;
    dwdata   = '0;
    dwstb    = '0;
    dwrite   = 1'b0;
    io_rdata = '0;
    io_ready = 1'b0;

    // Reset state
    #12;
    chk_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // RAM store then load back
    access("t1_store", 32'h8000_0010, 32'h0000_BEEF, 4'b0011, 1'b1, 0, 32'h0);
    access("t1_load",  32'h8000_0010, 32'h0, 4'b0000, 1'b0, 0, 32'h0);
    // IO load answered after 5 cycles
    access("t2_io",    32'h8001_0004, 32'h0, 4'b0000, 1'b0, 5, 32'h1234_5678);
    // IO load that never gets io_ready
    access("t3_tmo",   32'h8001_0004, 32'h0, 4'b0000, 1'b0, 1000, 32'h0);
    // Unmapped load
    access("t4_unmap", 32'h0000_1000, 32'h0, 4'b0000, 1'b0, 0, 32'h0);
    // io_ready on the timeout cycle itself
    access("t5_edge",  32'h8001_0008, 32'h0, 4'b0000, 1'b0, IO_TIMEOUT - 1, 32'hA5A5_0F0F);
    // IO store, immediate ready; RAM store with no strobes leaves memory intact
    access("t5_iost",  32'h8001_0FFC, 32'hCAFE_F00D, 4'b1001, 1'b1, 0, 32'h0);
    access("t5_st0",   32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 1'b1, 0, 32'h0);
    access("t5_ld0",   32'h8000_0010, 32'h0, 4'b0000, 1'b0, 0, 32'h0);

    // Reset during IO_WAIT abandons the access
    @(negedge clock);
    daddr  = 32'h8001_0040;
    dwrite = 1'b0;
    dwstb  = 4'b0000;
    dvalid = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("t6_in_io_wait", 32'(io_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    ref_err_addr = 32'h0;
    dvalid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    extra_pulses = 0;
    repeat (4) begin
      @(posedge clock);
      #1;
      if (dready) extra_pulses++;
    end
    chk("t6_no_dready", 32'(extra_pulses), 32'h0);
    access("t6_ram_load", 32'h8000_0010, 32'h0, 4'b0000, 1'b0, 0, 32'h0);

    // Randomized accesses over all three targets
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      wr   = 1'(($urandom_range(0, 1)));
      if (kind == 0) begin
        a = RAM_BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = RAM_BASE + ($urandom & 32'h0000_FFFF);
      end else if (kind == 1) begin
        a = IO_BASE + 32'($urandom_range(0, 4095));
      end else begin
        a = $urandom;
        for (int t = 0; t < 100 && region_of(a) != 0; t++) a = $urandom;
      end
      access($sformatf("rnd%0d", n), a, $urandom, 4'($urandom_range(0, 15)), wr,
             int'($urandom_range(0, 20)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
